mant_mul_initiator: RTL and testbench

Initiator for the mantissa-multiplier valid/ready interface. It generates normalized N-bit mantissa operand pairs from an internal LFSR, issues them on the operand channel and accepts the 2N-bit products on the result channel. It compares each product against an internally computed reference and reports pass/error counts. It sits opposite the multiplier responder in the mantissa test harness, as a synthesizable self-checking traffic source.

---
 rtl/mant_mul_initiator.sv | 161 ++++++++++++++++
 tb/tb_mant_mul_initiator.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mant_mul_initiator.sv
`default_nettype none
// ============================================================================
// Module   : mant_mul_initiator
// Purpose  : Self-checking traffic source for the mantissa-multiplier
//            valid/ready interface. Draws normalized N-bit operand pairs
//            from a 32-bit LFSR, issues them on the operand channel,
//            collects the 2N-bit products on the result channel and counts
//            matches / mismatches against an internally computed product.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            start               - run start pulse (honoured in IDLE/DONE)
//            A, B, in_valid      - operand channel (out), in_ready (in)
//            res_data, res_valid - result channel (in), res_ready (out)
//            busy, done          - run status
//            pass_count, err_count, first_err_idx - run results
// Revision : 1.0 - initial release
// ============================================================================
module mant_mul_initiator #(
    parameter int          N       = 11,
    parameter int          NUM_OPS = 16,
    parameter logic [31:0] SEED    = 32'h0000_0001,
    localparam int         CW      = $clog2(NUM_OPS + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N-1:0]    A,
    output logic [N-1:0]    B,
    output logic            in_valid,
    input  logic            in_ready,
    input  logic [2*N-1:0]  res_data,
    input  logic            res_valid,
    output logic            res_ready,
    output logic            busy,
    output logic            done,
    output logic [CW-1:0]   pass_count,
    output logic [CW-1:0]   err_count,
    output logic [CW-1:0]   first_err_idx
);

    // A zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [31:0]   C_SEED = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] C_LAST = CW'(NUM_OPS - 1);
    localparam logic [CW-1:0] C_ALL1 = '1;

    // Operands derived from the seed, used when a run (re)starts.
    localparam logic [N-1:0]  C_A_SEED = {1'b1, C_SEED[N-2:0]};
    localparam logic [N-1:0]  C_B_SEED = {1'b1, C_SEED[2*N-3:N-1]};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_COLLECT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t          r_state;
    logic [31:0]     r_lfsr;
    logic [2*N-1:0]  r_exp;
    logic [CW-1:0]   r_op_idx;

    logic [31:0]     w_lfsr_next;
    logic [N-1:0]    w_a_next;
    logic [N-1:0]    w_b_next;
    logic [2*N-1:0]  w_prod;
    logic            w_match;
    logic            w_last;

    // Fibonacci LFSR x^32+x^22+x^2+x+1, shifting left into bit 0.
    assign w_lfsr_next = {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};

    // Operands for the next pair come from the advanced LFSR state, so they
    // are ready on the outputs the cycle after the operand handshake.
    assign w_a_next = {1'b1, w_lfsr_next[N-2:0]};
    assign w_b_next = {1'b1, w_lfsr_next[2*N-3:N-1]};

    // Zero-extend before multiplying so the full 2N-bit product is kept.
    assign w_prod  = {{N{1'b0}}, A} * {{N{1'b0}}, B};
    assign w_match = (res_data == r_exp);
    assign w_last  = (r_op_idx == C_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_lfsr        <= C_SEED;
            r_exp         <= '0;
            r_op_idx      <= '0;
            A             <= '0;
            B             <= '0;
            in_valid      <= 1'b0;
            res_ready     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass_count    <= '0;
            err_count     <= '0;
            first_err_idx <= C_ALL1;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state       <= S_ISSUE;
                        r_lfsr        <= C_SEED;
                        r_op_idx      <= '0;
                        A             <= C_A_SEED;
                        B             <= C_B_SEED;
                        in_valid      <= 1'b1;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass_count    <= '0;
                        err_count     <= '0;
                        first_err_idx <= C_ALL1;
                    end
                end

                S_ISSUE: begin
                    // in_valid is high throughout this state, so in_ready
                    // alone marks the operand handshake.
                    if (in_ready) begin
                        r_state   <= S_COLLECT;
                        r_exp     <= w_prod;
                        r_lfsr    <= w_lfsr_next;
                        A         <= w_a_next;
                        B         <= w_b_next;
                        in_valid  <= 1'b0;
                        res_ready <= 1'b1;
                    end
                end

                S_COLLECT: begin
                    if (res_valid) begin
                        res_ready <= 1'b0;
                        r_op_idx  <= r_op_idx + C_ONE;
                        if (w_match) begin
                            pass_count <= pass_count + C_ONE;
                        end else begin
                            err_count <= err_count + C_ONE;
                            // Only the first mismatch of the run is recorded.
                            if (err_count == '0) begin
                                first_err_idx <= r_op_idx;
                            end
                        end
                        if (w_last) begin
                            r_state <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            r_state  <= S_ISSUE;
                            in_valid <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mant_mul_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_mant_mul_initiator
// Purpose  : Bench for mant_mul_initiator: randomized responder, behavioural
//            reference model and per-cycle output comparison.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mant_mul_initiator;

    localparam int          N       = 11;
    localparam int          NUM_OPS = 16;
    localparam logic [31:0] SEED    = 32'h0000_0001;
    localparam int          CW      = $clog2(NUM_OPS + 1);
    localparam int          ALL1    = (1 << CW) - 1;
    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

    localparam int P_IDLE = 0, P_ISSUE = 1, P_COLL = 2, P_DONE = 3;

    logic            clk       = 1'b0;
    logic            rst       = 1'b1;
    logic            start     = 1'b1;
    logic            in_ready  = 1'b0;
    logic            res_valid = 1'b0;
    logic [2*N-1:0]  res_data  = '0;
    logic [N-1:0]    A, B;
    logic            in_valid, res_ready, busy, done;
    logic [CW-1:0]   pass_count, err_count, first_err_idx;

    mant_mul_initiator #(.N(N), .NUM_OPS(NUM_OPS), .SEED(SEED)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .A             (A),
        .B             (B),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .res_data      (res_data),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .busy          (busy),
        .done          (done),
        .pass_count    (pass_count),
        .err_count     (err_count),
        .first_err_idx (first_err_idx)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: operands and products as plain integer arithmetic
    // ------------------------------------------------------------------
    function automatic logic [31:0] m_step(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

    function automatic longint m_opa(input logic [31:0] l);
        longint h;
        h = longint'(1) << (N - 1);
        return h + (longint'(l) % h);
    endfunction

    function automatic longint m_opb(input logic [31:0] l);
        longint h;
        h = longint'(1) << (N - 1);
        return h + ((longint'(l) / h) % h);
    endfunction

    int          m_phase = P_IDLE;
    logic [31:0] m_lfsr  = SEED_EFF;
    longint      m_A = 0, m_B = 0, m_exp = 0;
    int          m_idx = 0, m_pass = 0, m_err = 0, m_first = ALL1;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= P_IDLE;
            m_lfsr  <= SEED_EFF;
            m_A     <= 0;
            m_B     <= 0;
            m_idx   <= 0;
            m_pass  <= 0;
            m_err   <= 0;
            m_first <= ALL1;
        end else if ((m_phase == P_IDLE || m_phase == P_DONE) && start) begin
            m_phase <= P_ISSUE;
            m_lfsr  <= SEED_EFF;
            m_A     <= m_opa(SEED_EFF);
            m_B     <= m_opb(SEED_EFF);
            m_idx   <= 0;
            m_pass  <= 0;
            m_err   <= 0;
            m_first <= ALL1;
        end else if (m_phase == P_ISSUE && in_ready) begin
            m_phase <= P_COLL;
            m_exp   <= m_A * m_B;
            m_lfsr  <= m_step(m_lfsr);
            m_A     <= m_opa(m_step(m_lfsr));
            m_B     <= m_opb(m_step(m_lfsr));
        end else if (m_phase == P_COLL && res_valid) begin
            if (longint'(res_data) == m_exp) begin
                m_pass <= m_pass + 1;
            end else begin
                m_err <= m_err + 1;
                if (m_err == 0) m_first <= m_idx;
            end
            m_idx   <= m_idx + 1;
            m_phase <= (m_idx == NUM_OPS - 1) ? P_DONE : P_ISSUE;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("A",             longint'(A),             m_A);
        chk("B",             longint'(B),             m_B);
        chk("in_valid",      longint'(in_valid),      longint'(m_phase == P_ISSUE));
        chk("res_ready",     longint'(res_ready),     longint'(m_phase == P_COLL));
        chk("busy",          longint'(busy),          longint'(m_phase == P_ISSUE || m_phase == P_COLL));
        chk("done",          longint'(done),          longint'(m_phase == P_DONE));
        chk("pass_count",    longint'(pass_count),    longint'(m_pass));
        chk("err_count",     longint'(err_count),     longint'(m_err));
        chk("first_err_idx", longint'(first_err_idx), longint'(m_first));
    end

    // ------------------------------------------------------------------
    // Randomized responder
    // ------------------------------------------------------------------
    int                 ready_pct    = 0;
    int                 valid_pct    = 100;
    int                 spur_pct     = 0;
    int                 corrupt_pct  = 0;
    logic [NUM_OPS-1:0] corrupt_mask = '0;

    logic   r_pend = 1'b0;
    longint r_prod = 0;

    always @(posedge clk) begin
        if (rst) begin
            r_pend <= 1'b0;
        end else if (in_valid && in_ready) begin
            r_pend <= 1'b1;
            r_prod <= longint'(A) * longint'(B);
        end else if (res_valid && res_ready) begin
            r_pend <= 1'b0;
        end
    end

    always begin
        logic [2*N-1:0] x;
        @(negedge clk);
        #2;
        in_ready = (int'($urandom_range(0, 99)) < ready_pct);
        if (r_pend) begin
            x = '0;
            if (m_idx < NUM_OPS && corrupt_mask[m_idx]) x[0] = 1'b1;
            if (int'($urandom_range(0, 99)) < corrupt_pct)
                x = x ^ ((2*N)'(1) << $urandom_range(0, 2*N-1));
            res_valid = (int'($urandom_range(0, 99)) < valid_pct);
            res_data  = (2*N)'(r_prod) ^ x;
        end else begin
            res_valid = (int'($urandom_range(0, 99)) < spur_pct);
            res_data  = (2*N)'($urandom);
        end
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int rand_start_pct);
        int k;
        k = 0;
        while (!done && k < budget) begin
            start = (int'($urandom_range(0, 99)) < rand_start_pct);
            tick();
            k++;
        end
        start = 1'b0;
        chk("done_timeout", longint'(done), 1);
    endtask

    initial begin
        // Reset held with start asserted.
        rst   = 1'b1;
        start = 1'b1;
        repeat (3) tick();
        chk("rst_in_valid",  longint'(in_valid),      0);
        chk("rst_res_ready", longint'(res_ready),     0);
        chk("rst_busy",      longint'(busy),          0);
        chk("rst_done",      longint'(done),          0);
        chk("rst_A",         longint'(A),             0);
        chk("rst_B",         longint'(B),             0);
        chk("rst_pass",      longint'(pass_count),    0);
        chk("rst_err",       longint'(err_count),     0);
        chk("rst_first",     longint'(first_err_idx), ALL1);
        rst   = 1'b0;
        start = 1'b0;
        tick();

        // Run 1: backpressure, spurious res_valid, error on result #3.
        ready_pct    = 0;
        valid_pct    = 100;
        spur_pct     = 50;
        corrupt_mask = NUM_OPS'(16'h0008);
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_valid", longint'(in_valid),   1);
            chk("bp_A",        longint'(A),          1025);
            chk("bp_B",        longint'(B),          1024);
            chk("bp_pass",     longint'(pass_count), 0);
            tick();
        end
        ready_pct = 100;
        tick();
        chk("hs_in_valid",  longint'(in_valid),  0);
        chk("hs_res_ready", longint'(res_ready), 1);
        chk("model_exp0",   m_exp,               1049600);
        chk("op1_A",        longint'(A),         1027);
        chk("op1_B",        longint'(B),         1024);
        // start during COLLECT must not restart the run.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("nostart_pass", longint'(pass_count), 1);
        chk("nostart_A",    longint'(A),          1027);
        wait_done(1000, 0);
        chk("run1_pass",  longint'(pass_count),    15);
        chk("run1_err",   longint'(err_count),     1);
        chk("run1_first", longint'(first_err_idx), 3);
        chk("run1_busy",  longint'(busy),          0);
        repeat (3) tick();

        // Randomized runs, including restarts straight from DONE.
        for (int r = 0; r < 6; r++) begin
            ready_pct    = int'($urandom_range(20, 100));
            valid_pct    = int'($urandom_range(20, 100));
            spur_pct     = int'($urandom_range(0, 50));
            corrupt_pct  = int'($urandom_range(0, 40));
            corrupt_mask = NUM_OPS'($urandom);
            pulse_start();
            wait_done(3000, 5);
            repeat ($urandom_range(0, 3)) tick();
        end

        // Reset in COLLECT after four results.
        ready_pct    = 100;
        valid_pct    = 100;
        spur_pct     = 0;
        corrupt_pct  = 0;
        corrupt_mask = '0;
        pulse_start();
        begin
            int k;
            k = 0;
            while (!(int'(pass_count) + int'(err_count) == 4 && res_ready) && k < 200) begin
                tick();
                k++;
            end
            chk("mid_timeout", longint'(res_ready), 1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_pass",     longint'(pass_count),    0);
        chk("mid_err",      longint'(err_count),     0);
        chk("mid_busy",     longint'(busy),          0);
        chk("mid_in_valid", longint'(in_valid),      0);
        chk("mid_first",    longint'(first_err_idx), ALL1);
        pulse_start();
        chk("replay_A", longint'(A), 1025);
        chk("replay_B", longint'(B), 1024);
        wait_done(1000, 0);
        chk("clean_pass",  longint'(pass_count),    16);
        chk("clean_err",   longint'(err_count),     0);
        chk("clean_first", longint'(first_err_idx), ALL1);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
